// File: rtl/cpu_types_pkg.sv
// Shared CPU types: 32-bit word type and the fetch-stage state encoding.
// Ports: none (package).
// Imported by fetch_unit, fetch_if and the fetch testbench.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    HOLD    = 3'd2,
    DISCARD = 3'd3,
    HALTED  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch-stage signals between the I-cache port, hazard unit and IF/ID latch.
// Ports: none; modport fetch is the fetch_unit view, modport tb is the environment view.
// Clock and reset stay outside the bundle.
interface fetch_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imemload;
  logic  imemREN;
  word_t imemaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t iload;
  word_t npc_in;
  logic  ifid_enable;
  logic  ifid_flush;
  logic  halted;

  modport fetch (
    input  ihit, imemload, stall, redirect, redirect_pc, halt,
    output imemREN, imemaddr, iload, npc_in, ifid_enable, ifid_flush, halted
  );

  modport tb (
    output ihit, imemload, stall, redirect, redirect_pc, halt,
    input  imemREN, imemaddr, iload, npc_in, ifid_enable, ifid_flush, halted
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads, feeds the IF/ID register.
// Ports: CLK/RST (sync active-high); imem side ihit/imemload/imemREN/imemaddr;
//        control stall/redirect/redirect_pc/halt; IF/ID side iload/npc_in/ifid_enable/ifid_flush; halted.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t imemload,
  output logic  imemREN,
  output word_t imemaddr,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output word_t iload,
  output word_t npc_in,
  output logic  ifid_enable,
  output logic  ifid_flush,
  output logic  halted
);

  fetch_state_t fstate;
  word_t        pc;
  word_t        buf_instr;
  word_t        buf_npc;
  word_t        pend_pc;
  word_t        pc_plus4;
  word_t        target;

  // Natural 32-bit wrap: FFFF_FFFC + 4 = 0.
  assign pc_plus4 = pc + 32'd4;
  // Low address bits of the redirect target are forced to zero.
  assign target   = redirect_pc & ~32'h0000_0003;

  // Request side depends only on registered state (plus RST forcing).
  always_comb begin
    imemREN  = 1'b0;
    imemaddr = pc;
    halted   = 1'b0;
    if (RST) begin
      imemaddr = PC_INIT;
    end else begin
      imemREN = (fstate == FETCH) || (fstate == DISCARD);
      halted  = (fstate == HALTED);
    end
  end

  // IF/ID side: combinational so the latch sees it before the edge.
  always_comb begin
    ifid_enable = 1'b0;
    ifid_flush  = 1'b0;
    iload       = '0;
    npc_in      = '0;
    if (!RST) begin
      case (fstate)
        FETCH: begin
          if (redirect) begin
            ifid_flush = 1'b1;
          end else if (!halt && ihit && !stall) begin
            ifid_enable = 1'b1;
            iload       = imemload;
            npc_in      = pc_plus4;
          end
        end
        HOLD: begin
          iload  = buf_instr;
          npc_in = buf_npc;
          if (redirect) begin
            ifid_flush = 1'b1;
          end else if (!halt && !stall) begin
            ifid_enable = 1'b1;
          end
        end
        DISCARD: ifid_flush = redirect;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fstate    <= IDLE;
      pc        <= PC_INIT;
      buf_instr <= '0;
      buf_npc   <= '0;
      pend_pc   <= '0;
    end else begin
      case (fstate)
        IDLE: fstate <= FETCH;
        FETCH: begin
          if (redirect) begin
            // With data already returning, the old request is done and we
            // can jump immediately; otherwise wait for it to drain.
            if (ihit) begin
              pc <= target;
            end else begin
              pend_pc <= target;
              fstate  <= DISCARD;
            end
          end else if (halt) begin
            fstate <= HALTED;
          end else if (ihit) begin
            pc <= pc_plus4;
            if (stall) begin
              buf_instr <= imemload;
              buf_npc   <= pc_plus4;
              fstate    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc     <= target;
            fstate <= FETCH;
          end else if (halt) begin
            fstate <= HALTED;
          end else if (!stall) begin
            fstate <= FETCH;
          end
        end
        DISCARD: begin
          // Address stays on the old pc until memory answers; the newest
          // redirect target (including one arriving with ihit) wins.
          if (ihit) begin
            pc     <= redirect ? target : pend_pc;
            fstate <= FETCH;
          end else if (redirect) begin
            pend_pc <= target;
          end
        end
        HALTED: fstate <= HALTED;
        default: fstate <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized run against a reference model.
// Ports: none.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  localparam word_t PC0 = 32'h0000_0000;

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  logic  echo = 1'b1;
  word_t rand_load = '0;
  int    ntests = 0;
  int    nfail  = 0;

  fetch_if fif ();

  always #5 CLK = ~CLK;

  // Memory returns its own address in directed tests, random words otherwise.
  always_comb fif.imemload = echo ? fif.imemaddr : rand_load;

  fetch_unit #(.PC_INIT(PC0)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (fif.ihit),
    .imemload    (fif.imemload),
    .imemREN     (fif.imemREN),
    .imemaddr    (fif.imemaddr),
    .stall       (fif.stall),
    .redirect    (fif.redirect),
    .redirect_pc (fif.redirect_pc),
    .halt        (fif.halt),
    .iload       (fif.iload),
    .npc_in      (fif.npc_in),
    .ifid_enable (fif.ifid_enable),
    .ifid_flush  (fif.ifid_flush),
    .halted      (fif.halted)
  );

  // ---------------- reference model ----------------
  // Described as "what is the fetcher doing": warming up, streaming,
  // holding a stalled word, draining a squashed request, or stopped.
  word_t m_pc = PC0, m_buf_i = '0, m_buf_n = '0, m_pend = '0;
  bit    m_started = 0, m_holding = 0, m_draining = 0, m_stopped = 0;

  always @(posedge CLK) begin
    word_t t;
    t = {fif.redirect_pc[31:2], 2'b00};
    if (RST) begin
      m_pc = PC0; m_buf_i = '0; m_buf_n = '0; m_pend = '0;
      m_started = 0; m_holding = 0; m_draining = 0; m_stopped = 0;
    end else if (m_stopped) begin
      m_stopped = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_draining) begin
      if (fif.ihit) begin
        m_pc = fif.redirect ? t : m_pend;
        m_draining = 0;
      end else if (fif.redirect) begin
        m_pend = t;
      end
    end else if (m_holding) begin
      if (fif.redirect) begin
        m_pc = t; m_holding = 0;
      end else if (fif.halt) begin
        m_stopped = 1; m_holding = 0;
      end else if (!fif.stall) begin
        m_holding = 0;
      end
    end else begin
      if (fif.redirect) begin
        if (fif.ihit) m_pc = t;
        else begin m_pend = t; m_draining = 1; end
      end else if (fif.halt) begin
        m_stopped = 1;
      end else if (fif.ihit) begin
        if (fif.stall) begin
          m_buf_i = fif.imemload; m_buf_n = m_pc + 32'd4; m_holding = 1;
        end
        m_pc = m_pc + 32'd4;
      end
    end
  end

  logic  e_ren, e_halted, e_flush, e_en;
  word_t e_addr, e_iload, e_npc;

  always_comb begin
    logic active;
    active   = !RST && m_started && !m_stopped;
    e_ren    = active && !m_holding;
    e_addr   = RST ? PC0 : m_pc;
    e_halted = !RST && m_stopped;
    e_flush  = active && fif.redirect;
    e_en     = active && !m_draining && !fif.redirect && !fif.halt && !fif.stall
               && (m_holding || fif.ihit);
    e_iload  = '0;
    e_npc    = '0;
    if (active && m_holding) begin
      e_iload = m_buf_i; e_npc = m_buf_n;
    end else if (e_en) begin
      e_iload = fif.imemload; e_npc = m_pc + 32'd4;
    end
  end

  // ---------------- helpers ----------------
  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    fif.ihit = 0; fif.stall = 0; fif.redirect = 0; fif.halt = 0; fif.redirect_pc = '0;
  endtask

  task automatic do_reset();
    RST = 1; echo = 1; idle_inputs();
    next(); next();
    RST = 0;
  endtask

  // Stream with a zero-wait memory until the fetch address reaches addr.
  task automatic run_to(input word_t addr);
    int n = 0;
    fif.ihit = 1; fif.stall = 0;
    while (!(fif.imemREN && fif.imemaddr == addr) && n < 100) begin
      next(); n++;
    end
    ntests++;
    if (n >= 100) begin
      nfail++;
      $display("FAIL run_to: imemaddr=%h, required %h within 100 cycles", fif.imemaddr, addr);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1; idle_inputs(); fif.ihit = 1;
    next();
    @(negedge CLK);
    ntests++;
    if ({fif.imemREN, fif.ifid_enable, fif.ifid_flush, fif.halted} !== 4'b0) begin
      nfail++;
      $display("FAIL reset_ctrl: ren/en/flush/halted=%b, required 0000",
               {fif.imemREN, fif.ifid_enable, fif.ifid_flush, fif.halted});
    end
    ntests++;
    if (fif.imemaddr !== PC0 || fif.iload !== 32'h0 || fif.npc_in !== 32'h0) begin
      nfail++;
      $display("FAIL reset_data: addr=%h iload=%h npc=%h, required %h 0 0",
               fif.imemaddr, fif.iload, fif.npc_in, PC0);
    end
  endtask

  task automatic test_stream();
    do_reset();
    fif.ihit = 1;
    @(negedge CLK);
    ntests++;
    if (fif.ifid_enable !== 1'b0 || fif.imemREN !== 1'b0) begin
      nfail++;
      $display("FAIL stream_idle: en=%b ren=%b, required 0 0", fif.ifid_enable, fif.imemREN);
    end
    next();
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      ntests++;
      if (fif.ifid_enable !== 1'b1 || fif.npc_in !== 32'(4 * i) || fif.iload !== 32'(4 * (i - 1))) begin
        nfail++;
        $display("FAIL stream_%0d: en=%b npc=%h iload=%h, required 1 %h %h",
                 i, fif.ifid_enable, fif.npc_in, fif.iload, 32'(4 * i), 32'(4 * (i - 1)));
      end
      next();
    end
  endtask

  task automatic test_stall();
    do_reset();
    run_to(32'd8);
    fif.stall = 1;
    @(negedge CLK);
    ntests++;
    if (fif.ifid_enable !== 1'b0 || fif.imemREN !== 1'b1) begin
      nfail++;
      $display("FAIL stall_fetch: en=%b ren=%b, required 0 1", fif.ifid_enable, fif.imemREN);
    end
    next();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      ntests++;
      if (fif.imemREN !== 1'b0 || fif.iload !== 32'd8 || fif.ifid_enable !== 1'b0) begin
        nfail++;
        $display("FAIL stall_hold_%0d: ren=%b iload=%h en=%b, required 0 8 0",
                 i, fif.imemREN, fif.iload, fif.ifid_enable);
      end
      next();
    end
    fif.stall = 0;
    @(negedge CLK);
    ntests++;
    if (fif.ifid_enable !== 1'b1 || fif.iload !== 32'd8 || fif.npc_in !== 32'd12) begin
      nfail++;
      $display("FAIL stall_release: en=%b iload=%h npc=%h, required 1 8 c",
               fif.ifid_enable, fif.iload, fif.npc_in);
    end
    next();
    @(negedge CLK);
    ntests++;
    if (fif.imemaddr !== 32'd12 || fif.imemREN !== 1'b1) begin
      nfail++;
      $display("FAIL stall_resume: addr=%h ren=%b, required c 1", fif.imemaddr, fif.imemREN);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    run_to(32'd16);
    fif.ihit = 0; fif.redirect = 1; fif.redirect_pc = 32'h0000_0103;
    @(negedge CLK);
    ntests++;
    if (fif.ifid_flush !== 1'b1 || fif.ifid_enable !== 1'b0) begin
      nfail++;
      $display("FAIL redir_flush: flush=%b en=%b, required 1 0", fif.ifid_flush, fif.ifid_enable);
    end
    next();
    fif.redirect = 0;
    @(negedge CLK);
    ntests++;
    if (fif.ifid_flush !== 1'b0 || fif.imemaddr !== 32'd16 || fif.imemREN !== 1'b1 || fif.ifid_enable !== 1'b0) begin
      nfail++;
      $display("FAIL redir_discard: flush=%b addr=%h ren=%b en=%b, required 0 10 1 0",
               fif.ifid_flush, fif.imemaddr, fif.imemREN, fif.ifid_enable);
    end
    next();
    fif.ihit = 1;
    @(negedge CLK);
    ntests++;
    if (fif.imemaddr !== 32'd16 || fif.ifid_enable !== 1'b0 || fif.ifid_flush !== 1'b0) begin
      nfail++;
      $display("FAIL redir_drop: addr=%h en=%b flush=%b, required 10 0 0",
               fif.imemaddr, fif.ifid_enable, fif.ifid_flush);
    end
    next();
    @(negedge CLK);
    ntests++;
    if (fif.imemaddr !== 32'h0000_0100 || fif.imemREN !== 1'b1) begin
      nfail++;
      $display("FAIL redir_target: addr=%h ren=%b, required 100 1", fif.imemaddr, fif.imemREN);
    end
  endtask

  task automatic test_redirect_halt();
    do_reset();
    next();
    fif.ihit = 1; fif.redirect = 1; fif.halt = 1; fif.redirect_pc = 32'h0000_0200;
    @(negedge CLK);
    ntests++;
    if (fif.ifid_flush !== 1'b1 || fif.ifid_enable !== 1'b0) begin
      nfail++;
      $display("FAIL rh_flush: flush=%b en=%b, required 1 0", fif.ifid_flush, fif.ifid_enable);
    end
    next();
    fif.redirect = 0; fif.halt = 0;
    @(negedge CLK);
    ntests++;
    if (fif.imemaddr !== 32'h0000_0200 || fif.halted !== 1'b0 || fif.imemREN !== 1'b1) begin
      nfail++;
      $display("FAIL rh_target: addr=%h halted=%b ren=%b, required 200 0 1",
               fif.imemaddr, fif.halted, fif.imemREN);
    end
  endtask

  task automatic test_halt();
    do_reset();
    run_to(32'd40);
    fif.halt = 1;
    next();
    fif.halt = 0;
    for (int i = 0; i < 4; i++) begin
      fif.ihit = 1'($urandom); fif.stall = 1'($urandom);
      @(negedge CLK);
      ntests++;
      if (fif.halted !== 1'b1 || fif.imemREN !== 1'b0 || fif.ifid_enable !== 1'b0) begin
        nfail++;
        $display("FAIL halt_%0d: halted=%b ren=%b en=%b, required 1 0 0",
                 i, fif.halted, fif.imemREN, fif.ifid_enable);
      end
      next();
    end
    RST = 1;
    @(negedge CLK);
    ntests++;
    if (fif.imemaddr !== PC0 || fif.halted !== 1'b0 || fif.imemREN !== 1'b0) begin
      nfail++;
      $display("FAIL halt_rst: addr=%h halted=%b ren=%b, required %h 0 0",
               fif.imemaddr, fif.halted, fif.imemREN, PC0);
    end
    next();
    RST = 0;
    @(negedge CLK);
    ntests++;
    if (fif.halted !== 1'b0 || fif.imemaddr !== PC0) begin
      nfail++;
      $display("FAIL halt_exit: halted=%b addr=%h, required 0 %h", fif.halted, fif.imemaddr, PC0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    next();
    fif.ihit = 1; fif.redirect = 1; fif.redirect_pc = 32'hFFFF_FFFC;
    next();
    fif.redirect = 0;
    @(negedge CLK);
    ntests++;
    if (fif.imemaddr !== 32'hFFFF_FFFC || fif.ifid_enable !== 1'b1 || fif.npc_in !== 32'h0) begin
      nfail++;
      $display("FAIL wrap_npc: addr=%h en=%b npc=%h, required fffffffc 1 0",
               fif.imemaddr, fif.ifid_enable, fif.npc_in);
    end
    next();
    @(negedge CLK);
    ntests++;
    if (fif.imemaddr !== 32'h0) begin
      nfail++;
      $display("FAIL wrap_addr: addr=%h, required 0", fif.imemaddr);
    end
  endtask

  task automatic test_random();
    do_reset();
    echo = 0;
    for (int c = 0; c < 3000; c++) begin
      RST             = ($urandom_range(0, 199) == 0);
      fif.ihit        = ($urandom_range(0, 1) == 1);
      fif.stall       = ($urandom_range(0, 2) == 0);
      fif.redirect    = ($urandom_range(0, 7) == 0);
      fif.halt        = ($urandom_range(0, 63) == 0);
      fif.redirect_pc = $urandom;
      rand_load       = $urandom;
      @(negedge CLK);
      ntests++;
      if (fif.imemREN !== e_ren || fif.imemaddr !== e_addr || fif.halted !== e_halted) begin
        nfail++;
        $display("FAIL rand_req c=%0d: ren=%b addr=%h halted=%b, required %b %h %b",
                 c, fif.imemREN, fif.imemaddr, fif.halted, e_ren, e_addr, e_halted);
      end
      ntests++;
      if (fif.ifid_enable !== e_en || fif.ifid_flush !== e_flush) begin
        nfail++;
        $display("FAIL rand_ctl c=%0d: en=%b flush=%b, required %b %b",
                 c, fif.ifid_enable, fif.ifid_flush, e_en, e_flush);
      end
      ntests++;
      if (fif.iload !== e_iload || fif.npc_in !== e_npc) begin
        nfail++;
        $display("FAIL rand_data c=%0d: iload=%h npc=%h, required %h %h",
                 c, fif.iload, fif.npc_in, e_iload, e_npc);
      end
      next();
    end
    RST = 0;
    echo = 1;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_halt();
    test_halt();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
